roi_embed_axis: RTL

- Inverse of the ROI cropper. Takes an AXI-Stream of ROI pixels in raster order and rebuilds a full WIDTH x HEIGHT frame.
- ROI positions carry the incoming pixels. Every other position carries a programmable background value.
- Sits downstream of ROI processing and feeds full-frame consumers such as the display or frame writer.
- Both interfaces are AXI-Stream with full tready backpressure.

---
 rtl/roi_embed_axis_if.sv | 14 +
 rtl/roi_embed_axis.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/roi_embed_axis_if.sv
// AXI-Stream bundle used on both sides of the ROI embedder.
// tuser marks start of frame on the master side; the slave side ignores it.
interface roi_embed_axis_if #(
  parameter int BIT_DATA = 8
);
  logic [BIT_DATA-1:0] tdata;
  logic                tvalid;
  logic                tlast;
  logic                tuser;
  logic                tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/roi_embed_axis.sv
// Rebuilds a full WIDTH x HEIGHT raster from an ROI pixel stream, filling
// every non-ROI position with a background value latched at frame start.
module roi_embed_axis #(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int BIT_DATA  = 8,
  parameter int BIT_COORD = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 enable_i,
  input  logic [BIT_COORD-1:0] xy_0_i,
  input  logic [BIT_COORD-1:0] xy_1_i,
  input  logic [BIT_DATA-1:0]  bg_i,
  roi_embed_axis_if.slave      s_axis,
  roi_embed_axis_if.master     m_axis,
  output logic                 frame_done_o,
  output logic                 err_o
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int CW = $clog2(WIDTH * HEIGHT + 1);

  localparam logic [10:0]   WIDTH_F  = 11'(WIDTH);
  localparam logic [9:0]    HEIGHT_F = 10'(HEIGHT);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state;
  logic [XW-1:0]       r_x, r_xlo, r_xhi;
  logic [YW-1:0]       r_y, r_ylo, r_yhi;
  logic [BIT_DATA-1:0] r_bg;
  logic                r_ok;
  logic [CW-1:0]       r_n;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic                r_hold;
  logic [BIT_DATA-1:0] r_tdata;
  logic                r_tvalid;
  logic                r_tuser;
  logic                r_tlast;
  logic                r_fdone;
  logic                r_err;

  // Raw corner fields and the normalised rectangle they describe
  logic [10:0]   w_x0, w_x1, w_xlo_f, w_xhi_f;
  logic [9:0]    w_y0, w_y1, w_ylo_f, w_yhi_f;
  logic          w_ok_new;
  logic [XW-1:0] w_xlo_new, w_xhi_new, w_xspan;
  logic [YW-1:0] w_ylo_new, w_yhi_new, w_yspan;
  logic [CW-1:0] w_n_new;

  assign w_x0 = xy_0_i[26:16];
  assign w_y0 = xy_0_i[9:0];
  assign w_x1 = xy_1_i[26:16];
  assign w_y1 = xy_1_i[9:0];

  assign w_xlo_f = (w_x0 < w_x1) ? w_x0 : w_x1;
  assign w_xhi_f = (w_x0 < w_x1) ? w_x1 : w_x0;
  assign w_ylo_f = (w_y0 < w_y1) ? w_y0 : w_y1;
  assign w_yhi_f = (w_y0 < w_y1) ? w_y1 : w_y0;

  assign w_ok_new = (w_x0 != 11'd0) && (w_x1 != 11'd0) &&
                    (w_y0 != 10'd0) && (w_y1 != 10'd0) &&
                    (w_xhi_f <= WIDTH_F) && (w_yhi_f <= HEIGHT_F);

  assign w_xlo_new = w_xlo_f[XW-1:0];
  assign w_xhi_new = w_xhi_f[XW-1:0];
  assign w_ylo_new = w_ylo_f[YW-1:0];
  assign w_yhi_new = w_yhi_f[YW-1:0];
  assign w_xspan   = w_xhi_new - w_xlo_new + X_ONE;
  assign w_yspan   = w_yhi_new - w_ylo_new + Y_ONE;
  assign w_n_new   = CW'(w_xspan) * CW'(w_yspan);

  logic w_unused;
  assign w_unused = ^{xy_0_i[BIT_COORD-1:27], xy_0_i[15:10],
                      xy_1_i[BIT_COORD-1:27], xy_1_i[15:10], s_axis.tuser};

  // Frame sequencing and per-frame context selection
  logic w_run, w_frame_end, w_restart, w_start;

  assign w_run       = (r_state == RUN);
  assign w_frame_end = w_run && r_tvalid && m_axis.tready && r_tlast;
  assign w_restart   = w_frame_end && enable_i;
  assign w_start     = (!w_run && enable_i) || w_restart;

  // On a back-to-back restart the (1,1) beat is loaded in the same cycle the
  // previous tlast leaves, so it must see the freshly sampled context.
  logic [XW-1:0]       w_xlo, w_xhi;
  logic [YW-1:0]       w_ylo, w_yhi;
  logic [BIT_DATA-1:0] w_bg;
  logic                w_ok, w_done;
  logic [CW-1:0]       w_n, w_cnt, w_k;

  assign w_xlo  = w_restart ? w_xlo_new : r_xlo;
  assign w_xhi  = w_restart ? w_xhi_new : r_xhi;
  assign w_ylo  = w_restart ? w_ylo_new : r_ylo;
  assign w_yhi  = w_restart ? w_yhi_new : r_yhi;
  assign w_bg   = w_restart ? bg_i      : r_bg;
  assign w_ok   = w_restart ? w_ok_new  : r_ok;
  assign w_n    = w_restart ? w_n_new   : r_n;
  assign w_done = w_restart ? 1'b0      : r_done;
  assign w_cnt  = w_restart ? '0        : r_cnt;
  assign w_k    = w_cnt + C_ONE;

  // Position handling: r_hold parks the counters after the tlast beat is loaded
  logic w_load_en, w_inside, w_sready, w_s_hs, w_adv;
  logic w_x_end, w_last_pos, w_short, w_long;

  assign w_load_en = w_run && (!r_hold || w_restart) && (!r_tvalid || m_axis.tready);
  assign w_inside  = w_ok && !w_done &&
                     (r_x >= w_xlo) && (r_x <= w_xhi) &&
                     (r_y >= w_ylo) && (r_y <= w_yhi);
  assign w_sready  = w_load_en && w_inside;
  assign w_s_hs    = w_sready && s_axis.tvalid;
  assign w_adv     = w_load_en && (!w_inside || s_axis.tvalid);
  assign w_x_end   = (r_x == X_LAST);
  assign w_last_pos = w_x_end && (r_y == Y_LAST);

  assign w_short = w_s_hs && s_axis.tlast && (w_k < w_n);
  assign w_long  = w_s_hs && !s_axis.tlast && (w_k == w_n);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state  <= IDLE;
      r_x      <= X_ONE;
      r_y      <= Y_ONE;
      r_xlo    <= '0;
      r_xhi    <= '0;
      r_ylo    <= '0;
      r_yhi    <= '0;
      r_bg     <= '0;
      r_ok     <= 1'b0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_hold   <= 1'b0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      r_fdone  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fdone <= w_frame_end;

      if (w_start) begin
        r_xlo <= w_xlo_new;
        r_xhi <= w_xhi_new;
        r_ylo <= w_ylo_new;
        r_yhi <= w_yhi_new;
        r_bg  <= bg_i;
        r_ok  <= w_ok_new;
        r_n   <= w_n_new;
      end

      // Error is cleared at frame start but a beat in that same cycle may set it
      r_err  <= w_short || w_long || (r_err && !w_start);
      r_done <= w_short || (r_done && !w_start);
      r_cnt  <= w_s_hs ? w_k : (w_start ? '0 : r_cnt);

      case (r_state)
        IDLE: if (enable_i) r_state <= RUN;
        RUN:  if (w_frame_end && !enable_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_adv) begin
        r_tdata  <= w_inside ? s_axis.tdata : w_bg;
        r_tvalid <= 1'b1;
        r_tuser  <= (r_x == X_ONE) && (r_y == Y_ONE);
        r_tlast  <= w_last_pos;
        r_hold   <= w_last_pos;
        if (w_x_end) begin
          r_x <= X_ONE;
          r_y <= w_last_pos ? Y_ONE : r_y + Y_ONE;
        end else begin
          r_x <= r_x + X_ONE;
        end
      end else if (w_load_en || w_frame_end) begin
        r_tvalid <= 1'b0;
        r_tuser  <= 1'b0;
        r_tlast  <= 1'b0;
        r_hold   <= 1'b0;
      end
    end
  end

  assign s_axis.tready = w_sready;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tlast  = r_tlast;
  assign frame_done_o  = r_fdone;
  assign err_o         = r_err;

endmodule
